keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter HOLD_W, default 6, which sets the width of hold_ms.
REQ-002 SHALL have port clk, input, 1 bit: scan clock (1000 Hz divided clock; 1 cycle = 1 ms).
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port col, input, 4 bits: column drive from the scanner; a low bit selects that column.
REQ-005 SHALL have port row, output, 4 bits: emulated row lines; 1 = released, pulled high.
REQ-006 SHALL have port req, input, 1 bit: a 1-cycle pulse that starts one key press.
REQ-007 SHALL have port req_key, input, 4 bits: key code. 0-9 = digits, 10 = START, 11 = CLEAR, 12 = CONFIRM, 13-15 = invalid.
REQ-008 SHALL have port hold_ms, input, HOLD_W bits: stable-closed duration in cycles.
REQ-009 SHALL have port bounce_ms, input, 3 bits: bounce duration in cycles at press and at release.
REQ-010 SHALL have port busy, output, 1 bit: a press sequence is in progress.
REQ-011 SHALL have port done, output, 1 bit: 1-cycle pulse at the end of a press sequence.
REQ-012 SHALL have port err, output, 1 bit: 1-cycle pulse when a request carries an invalid key code.

Function
REQ-013 SHALL latch req_key, hold_ms and bounce_ms on the clock edge where req=1 and the FSM is IDLE; the latched copies SHALL be used for the whole sequence.
REQ-014 SHALL map each key to a (column bit, row bit) pair, where the column bit is the col bit that must be low and the row bit is the row bit that is pulled low:
- Keys 1, 2, 3, 4 SHALL use column bits 3, 2, 1, 0 and row bit 3.
- Keys 5, 6, 7, 8 SHALL use column bits 3, 2, 1, 0 and row bit 2.
- Keys 9, 0 SHALL use column bits 3, 2 and row bit 1.
- START, CLEAR, CONFIRM SHALL use column bits 3, 2, 1 and row bit 0.
REQ-015 SHALL drive row combinationally: when contact is closed and col[key column bit]=0, row = 4'b1111 with the key row bit cleared; otherwise row = 4'b1111. Multiple low col bits (for example 4'b0000) SHALL still select the key when its column bit is low.
REQ-016 SHALL implement FSM states IDLE, B_IN, HOLD, B_OUT, DONE, with a cycle counter cnt.
REQ-017 IDLE SHALL transition as follows:
- req with a valid code -> B_IN if bounce_ms>0, else HOLD.
- req with an invalid code -> remain in IDLE and pulse err for 1 cycle.
REQ-018 B_IN SHALL last exactly bounce_ms cycles, with contact closed when cnt is even (first cycle closed); it SHALL then go to HOLD.
REQ-019 HOLD SHALL last exactly max(hold_ms,1) cycles with contact closed; it SHALL then go to B_OUT if bounce_ms>0, else to DONE.
REQ-020 B_OUT SHALL last exactly bounce_ms cycles, with contact closed when cnt is odd (first cycle open); it SHALL then go to DONE.
REQ-021 DONE SHALL last 1 cycle with contact open and done=1, then go to IDLE.
REQ-022 Contact SHALL be open in IDLE and DONE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 req while busy=1 SHALL be ignored: no latch, no err, and no effect on the current sequence.
REQ-025 The latency from the req edge to the first closed-contact cycle SHALL be 0 cycles: contact is closed in the cycle that follows that edge.
REQ-026 cnt SHALL reset to 0 on every state entry and SHALL never wrap within a state; HOLD_W sets its maximum range.
REQ-027 col changes mid-sequence SHALL affect row immediately (combinational) and SHALL NOT alter FSM timing.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, latched key=0, row=4'b1111, busy=0, done=0, err=0.
REQ-029 Reset asserted mid-sequence SHALL release row to 4'b1111 immediately; no done pulse SHALL follow.
REQ-030 After reset release, the first req SHALL be honoured on the next clock edge.

Verification
REQ-031 The bench SHALL apply key 5, hold_ms=20, bounce_ms=0, col=4'b0111 -> row=4'b1011 for exactly 20 cycles, then 4'b1111, with done pulsing 1 cycle later.
REQ-032 The bench SHALL apply key 5 as above with col=4'b1011 throughout -> row stays 4'b1111, and done still pulses after 21 cycles.
REQ-033 The bench SHALL apply CONFIRM, hold_ms=16, bounce_ms=3, col=4'b1101 -> row pattern 1110,1111,1110, then 1110 for 16 cycles, then 1111,1110,1111, then done; busy high for 23 cycles.
REQ-034 The bench SHALL apply req_key=14 -> err high for 1 cycle, busy stays 0, row stays 4'b1111; it SHALL also apply req during HOLD of a key 2 press -> ignored, with key 2 timing unchanged.
REQ-035 The bench SHALL apply key 0, hold_ms=0, bounce_ms=0, col=4'b0000 -> row=4'b1101 for exactly 1 cycle, then done.
REQ-036 The bench SHALL assert rst_n=0 during HOLD of key 1 with col=4'b0111 -> row=4'b1111 with no clock edge, busy=0, and no done pulse.

Source files
------------

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : Emulates one key of a 4x4 matrix keypad being pressed.
//               A request plays a bounce / hold / bounce contact pattern.
//               While the contact is closed, the key's row line is pulled low
//               whenever the scanner drives the key's column low.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
  parameter int HOLD_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  input  logic              req,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] hold_ms,
  input  logic [2:0]        bounce_ms,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The counter must span both the hold time and the 3-bit bounce time.
  localparam int CNT_W = (HOLD_W > 3) ? HOLD_W : 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] B_IN  = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] B_OUT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        bounce_q;

  logic              key_valid;
  logic              hold_last;
  logic              bounce_last;
  logic              contact;
  logic [1:0]        col_bit;
  logic [1:0]        row_bit;

  assign key_valid   = (req_key <= 4'd12);
  assign hold_last   = (hold_q == '0) || (cnt == CNT_W'(hold_q) - CNT_W'(1));
  assign bounce_last = (cnt == CNT_W'(bounce_q) - CNT_W'(1));

  // Sequence FSM: latches the request, then times each contact phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      key_q    <= '0;
      hold_q   <= '0;
      bounce_q <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            key_q    <= req_key;
            hold_q   <= hold_ms;
            bounce_q <= bounce_ms;
            if (!key_valid) begin
              err <= 1'b1;
            end else if (bounce_ms != 3'd0) begin
              state <= B_IN;
            end else begin
              state <= HOLD;
            end
          end
        end
        B_IN: begin
          if (bounce_last) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (hold_last) begin
            state <= (bounce_q != 3'd0) ? B_OUT : DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        B_OUT: begin
          if (bounce_last) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Contact pattern: press bounce starts closed, release bounce starts open.
  always_comb begin
    contact = 1'b0;
    case (state)
      B_IN:    contact = ~cnt[0];
      HOLD:    contact = 1'b1;
      B_OUT:   contact = cnt[0];
      default: contact = 1'b0;
    endcase
  end

  // Key code to matrix position (column bit that must be low, row bit pulled).
  always_comb begin
    col_bit = 2'd0;
    row_bit = 2'd0;
    case (key_q)
      4'd1:    begin col_bit = 2'd3; row_bit = 2'd3; end
      4'd2:    begin col_bit = 2'd2; row_bit = 2'd3; end
      4'd3:    begin col_bit = 2'd1; row_bit = 2'd3; end
      4'd4:    begin col_bit = 2'd0; row_bit = 2'd3; end
      4'd5:    begin col_bit = 2'd3; row_bit = 2'd2; end
      4'd6:    begin col_bit = 2'd2; row_bit = 2'd2; end
      4'd7:    begin col_bit = 2'd1; row_bit = 2'd2; end
      4'd8:    begin col_bit = 2'd0; row_bit = 2'd2; end
      4'd9:    begin col_bit = 2'd3; row_bit = 2'd1; end
      4'd0:    begin col_bit = 2'd2; row_bit = 2'd1; end
      4'd10:   begin col_bit = 2'd3; row_bit = 2'd0; end
      4'd11:   begin col_bit = 2'd2; row_bit = 2'd0; end
      4'd12:   begin col_bit = 2'd1; row_bit = 2'd0; end
      default: begin col_bit = 2'd0; row_bit = 2'd0; end
    endcase
  end

  // Row lines follow the column drive immediately while the contact is closed.
  always_comb begin
    row = 4'b1111;
    if (contact && !col[col_bit]) begin
      row[row_bit] = 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench for keypad_emulator. Each press pushes
//               its expected per-cycle {row,busy,done,err} into a queue that
//               is popped and compared as the DUT runs the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       req;
  logic [3:0] req_key;
  logic [5:0] hold_ms;
  logic [2:0] bounce_ms;
  logic       busy;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;
  logic [6:0] exp_q[$];

  keypad_emulator #(.HOLD_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .req       (req),
    .req_key   (req_key),
    .hold_ms   (hold_ms),
    .bounce_ms (bounce_ms),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Keypad grid order: 1..9,0 fill rows 3,2,1 left to right; specials on row 0.
  function automatic logic [3:0] model_row(input logic [3:0] key, input logic [3:0] colv,
                                           input bit closed);
    int pos;
    int rb;
    int cb;
    logic [3:0] r;
    if (key <= 4'd9) begin
      pos = (key == 4'd0) ? 9 : int'(key) - 1;
      rb  = 3 - pos / 4;
      cb  = 3 - pos % 4;
    end else begin
      rb = 0;
      cb = 3 - (int'(key) - 10);
    end
    r = 4'b1111;
    if (closed && colv[cb] == 1'b0) r[rb] = 1'b0;
    return r;
  endfunction

  task automatic push_seq(input logic [3:0] key, input int hold, input int bounce,
                          input logic [3:0] colv);
    int h;
    if (key > 4'd12) begin
      exp_q.push_back({4'b1111, 3'b001});
      return;
    end
    h = (hold == 0) ? 1 : hold;
    for (int i = 0; i < bounce; i++) exp_q.push_back({model_row(key, colv, (i % 2) == 0), 3'b100});
    for (int i = 0; i < h; i++)      exp_q.push_back({model_row(key, colv, 1'b1), 3'b100});
    for (int i = 0; i < bounce; i++) exp_q.push_back({model_row(key, colv, (i % 2) == 1), 3'b100});
    exp_q.push_back({4'b1111, 3'b110});
  endtask

  // Drive one request and compare every cycle until the expected sequence is
  // consumed; optionally inject extra requests during the hold phase.
  task automatic press(input logic [3:0] key, input int hold, input int bounce,
                       input logic [3:0] colv, input bit inject);
    int i;
    logic [6:0] e;
    push_seq(key, hold, bounce, colv);
    @(negedge clk);
    req       = 1'b1;
    req_key   = key;
    hold_ms   = 6'(hold);
    bounce_ms = 3'(bounce);
    col       = colv;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      req = 1'b0;
      if (inject && i == 4) begin
        req = 1'b1; req_key = 4'd13; hold_ms = 6'd1; bounce_ms = 3'd0;
      end else if (inject && i == 6) begin
        req = 1'b1; req_key = 4'd7; hold_ms = 6'd2; bounce_ms = 3'd5;
      end
      e = exp_q.pop_front();
      check("seq", {25'd0, row, busy, done, err}, {25'd0, e});
      i++;
    end
    @(negedge clk);
    req = 1'b0;
    check("idle", {25'd0, row, busy, done, err}, {25'd0, 4'b1111, 3'b000});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    col         = 4'b1111;
    req         = 1'b0;
    req_key     = 4'd0;
    hold_ms     = 6'd0;
    bounce_ms   = 3'd0;

    repeat (2) @(negedge clk);
    check("rst_state", {25'd0, row, busy, done, err}, {25'd0, 4'b1111, 3'b000});
    rst_n = 1'b1;

    press(4'd5, 20, 0, 4'b0111, 1'b0);
    press(4'd5, 20, 0, 4'b1011, 1'b0);
    press(4'd12, 16, 3, 4'b1101, 1'b0);
    press(4'd14, 5, 2, 4'b0000, 1'b0);
    press(4'd2, 8, 2, 4'b1011, 1'b1);
    press(4'd0, 0, 0, 4'b0000, 1'b0);

    // Reset in the middle of a key 1 hold.
    @(negedge clk);
    req = 1'b1; req_key = 4'd1; hold_ms = 6'd10; bounce_ms = 3'd0; col = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
      check("k1_hold", {28'd0, row}, {28'd0, 4'b0111});
    end
    #2 rst_n = 1'b0;
    #1 check("rst_async", {25'd0, row, busy, done, err}, {25'd0, 4'b1111, 3'b000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {25'd0, row, busy, done, err}, {25'd0, 4'b1111, 3'b000});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_done", {29'd0, busy, done, err}, {29'd0, 3'b000});
    end

    // First request straight after reset, then a few random presses.
    press(4'd1, 3, 1, 4'b0000, 1'b0);
    for (int n = 0; n < 8; n++) begin
      press(4'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
